id_ex_pipeline_reg: RTL
=======================

Name: id_ex_pipeline_reg

Overview:
- ID/EX pipeline register of the 5-stage LEGv8 CPU, sitting directly upstream of the EX-stage operand/immediate-select logic.
- Latches decoded operands, immediates and control from ID each cycle and presents them to EX.
- Integrates load-use hazard detection: generates a one-cycle stall to IF/ID and PC, and injects a bubble into EX.
- Also supports branch flush, external hold and a saturating bubble counter.

Parameters:
- DATA_W, 64, width of register-file read data D1/D2.
- REG_ADDR_W, 5, register specifier width.
- ZERO_REG, 31, index of XZR; never a hazard source.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_D1  in  DATA_W  register file read data 1 (Rn).
- id_D2  in  DATA_W  register file read data 2 (Rm/Rt).
- id_Imm12  in  12  I-type immediate.
- id_Imm9  in  9  D-type offset.
- id_Rn, id_Rm, id_Rd  in  REG_ADDR_W each  source and destination specifiers.
- id_uses_Rm  in  1  instruction reads the second source.
- id_LDUR_STUR, id_ALUsrc  in  1 each  immediate-select controls.
- id_ALUop  in  3  ALU operation.
- id_MemRead, id_MemWrite, id_RegWrite, id_MemToReg  in  1 each.
- flush  in  1  branch taken in later stage; kill the ID instruction.
- ext_hold  in  1  downstream (memory) stall; freeze this register.
- ex_valid  out  1  registered valid.
- ex_D1, ex_D2  out  DATA_W each  registered data.
- ex_Imm12  out  12; ex_Imm9  out  9.
- ex_Rn, ex_Rm, ex_Rd  out  REG_ADDR_W each.
- ex_LDUR_STUR, ex_ALUsrc  out  1 each; ex_ALUop  out  3.
- ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemToReg  out  1 each.
- hazard_stall  out  1  combinational; IF/ID and PC must hold when high.
- bubble_count  out  CNT_W  saturating count of bubbles injected.

Behaviour:
- Reset (reset_n low, asynchronous): every ex_* output is 0 and bubble_count is 0. hazard_stall is 0 as a consequence, since ex_valid=0. Release is synchronous to clk.
- hazard_stall = ex_valid & ex_MemRead & (ex_Rd != ZERO_REG) & id_valid & ((id_Rn == ex_Rd) | (id_uses_Rm & id_Rm == ex_Rd)) & ~flush.
- Update priority on each rising edge, highest first:
  - flush = 1: load a bubble.
  - ext_hold = 1: all ex_* hold their values; bubble_count holds.
  - hazard_stall = 1: load a bubble; bubble_count += 1.
  - otherwise: load all id_* into ex_*; ex_valid = id_valid.
- Bubble definition: ex_valid, ex_MemRead, ex_MemWrite, ex_RegWrite and ex_MemToReg are 0. All other ex_* fields are also 0 (deterministic, not don't-care).
- Flush bubbles are not counted; only hazard bubbles are counted.
- Load-use latency: exactly one bubble per load-use pair. The bubble has MemRead=0, so hazard_stall deasserts the following cycle and the held ID instruction advances.
- ext_hold with a hazard present: the register is frozen and hazard_stall stays high, because its inputs are unchanged. No bubble is inserted and no count increment occurs until ext_hold drops.
- flush with a hazard present: flush wins, hazard_stall is forced low, and one uncounted bubble is inserted.
- XZR: a load to X31 never stalls.
- A store following a load to the same register stalls when either the Rn match or the Rm match (with id_uses_Rm) is true.
- bubble_count saturates at 2^CNT_W-1 with no wrap.
- Data paths are pure registers: no transformation of D1, D2 or the immediates. Sign/zero extension belongs to EX.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with ex_valid=1 and ex_MemRead=1 → all outputs 0 immediately (before the next clock edge), hazard_stall=0, bubble_count=0.
- Pass-through: id_valid=1, id_D1=64'h1234, id_D2=64'hFFFF_0000_0000_0001, id_Imm12=12'h001, id_Imm9=9'h102, id_ALUsrc=1 → identical values on ex_* one cycle later, hazard_stall=0.
- Load-use: EX holds LDUR X3 (ex_MemRead=1, ex_Rd=3); ID holds ADD with id_Rn=3 → hazard_stall=1 for exactly one cycle. Next cycle ex_valid=0, ex_RegWrite=0, bubble_count=1. The ADD then reaches EX on the following edge.
- XZR and no-match: ex_Rd=31 with id_Rn=31 → no stall. ex_Rd=3 with id_Rm=3 and id_uses_Rm=0 → no stall.
- Priority: hazard active together with flush=1 → hazard_stall=0, bubble inserted, bubble_count unchanged. Hazard active with ext_hold=1 for 3 cycles → ex_* frozen and hazard_stall=1 throughout; after ext_hold drops, one bubble and bubble_count increments by 1.
- Saturation: CNT_W=2 with 5 consecutive load-use pairs → bubble_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX pipeline register bundle: decoded ID fields in, registered EX fields out,
// plus flush/hold controls, the load-use stall and the bubble counter.
interface id_ex_pipeline_reg_if #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [DATA_W-1:0]     id_D1;
  logic [DATA_W-1:0]     id_D2;
  logic [11:0]           id_Imm12;
  logic [8:0]            id_Imm9;
  logic [REG_ADDR_W-1:0] id_Rn;
  logic [REG_ADDR_W-1:0] id_Rm;
  logic [REG_ADDR_W-1:0] id_Rd;
  logic                  id_uses_Rm;
  logic                  id_LDUR_STUR;
  logic                  id_ALUsrc;
  logic [2:0]            id_ALUop;
  logic                  id_MemRead;
  logic                  id_MemWrite;
  logic                  id_RegWrite;
  logic                  id_MemToReg;
  logic                  flush;
  logic                  ext_hold;

  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_D1;
  logic [DATA_W-1:0]     ex_D2;
  logic [11:0]           ex_Imm12;
  logic [8:0]            ex_Imm9;
  logic [REG_ADDR_W-1:0] ex_Rn;
  logic [REG_ADDR_W-1:0] ex_Rm;
  logic [REG_ADDR_W-1:0] ex_Rd;
  logic                  ex_LDUR_STUR;
  logic                  ex_ALUsrc;
  logic [2:0]            ex_ALUop;
  logic                  ex_MemRead;
  logic                  ex_MemWrite;
  logic                  ex_RegWrite;
  logic                  ex_MemToReg;
  logic                  hazard_stall;
  logic [CNT_W-1:0]      bubble_count;

  modport master (
    output id_valid, id_D1, id_D2, id_Imm12, id_Imm9, id_Rn, id_Rm, id_Rd,
           id_uses_Rm, id_LDUR_STUR, id_ALUsrc, id_ALUop,
           id_MemRead, id_MemWrite, id_RegWrite, id_MemToReg, flush, ext_hold,
    input  ex_valid, ex_D1, ex_D2, ex_Imm12, ex_Imm9, ex_Rn, ex_Rm, ex_Rd,
           ex_LDUR_STUR, ex_ALUsrc, ex_ALUop,
           ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemToReg,
           hazard_stall, bubble_count
  );

  modport slave (
    input  id_valid, id_D1, id_D2, id_Imm12, id_Imm9, id_Rn, id_Rm, id_Rd,
           id_uses_Rm, id_LDUR_STUR, id_ALUsrc, id_ALUop,
           id_MemRead, id_MemWrite, id_RegWrite, id_MemToReg, flush, ext_hold,
    output ex_valid, ex_D1, ex_D2, ex_Imm12, ex_Imm9, ex_Rn, ex_Rm, ex_Rd,
           ex_LDUR_STUR, ex_ALUsrc, ex_ALUop,
           ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemToReg,
           hazard_stall, bubble_count
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// LEGv8 ID/EX pipeline register with load-use hazard detection, branch flush,
// external hold and a saturating count of hazard bubbles.
module id_ex_pipeline_reg #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  id_ex_pipeline_reg_if.slave  bus
);
  localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(ZERO_REG);

  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_D1;
  logic [DATA_W-1:0]     ex_D2;
  logic [11:0]           ex_Imm12;
  logic [8:0]            ex_Imm9;
  logic [REG_ADDR_W-1:0] ex_Rn;
  logic [REG_ADDR_W-1:0] ex_Rm;
  logic [REG_ADDR_W-1:0] ex_Rd;
  logic                  ex_LDUR_STUR;
  logic                  ex_ALUsrc;
  logic [2:0]            ex_ALUop;
  logic                  ex_MemRead;
  logic                  ex_MemWrite;
  logic                  ex_RegWrite;
  logic                  ex_MemToReg;
  logic [CNT_W-1:0]      bubble_count;
  logic                  hazard_stall;

  // A load in EX whose destination feeds the ID instruction; flush overrides it.
  always_comb begin
    hazard_stall = ex_valid & ex_MemRead & (ex_Rd != XZR) & bus.id_valid &
                   ((bus.id_Rn == ex_Rd) | (bus.id_uses_Rm & (bus.id_Rm == ex_Rd))) &
                   ~bus.flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_D1        <= '0;
      ex_D2        <= '0;
      ex_Imm12     <= '0;
      ex_Imm9      <= '0;
      ex_Rn        <= '0;
      ex_Rm        <= '0;
      ex_Rd        <= '0;
      ex_LDUR_STUR <= 1'b0;
      ex_ALUsrc    <= 1'b0;
      ex_ALUop     <= '0;
      ex_MemRead   <= 1'b0;
      ex_MemWrite  <= 1'b0;
      ex_RegWrite  <= 1'b0;
      ex_MemToReg  <= 1'b0;
      bubble_count <= '0;
    end else if (bus.flush || (!bus.ext_hold && hazard_stall)) begin
      // Bubbles clear every field so EX sees a deterministic NOP.
      ex_valid     <= 1'b0;
      ex_D1        <= '0;
      ex_D2        <= '0;
      ex_Imm12     <= '0;
      ex_Imm9      <= '0;
      ex_Rn        <= '0;
      ex_Rm        <= '0;
      ex_Rd        <= '0;
      ex_LDUR_STUR <= 1'b0;
      ex_ALUsrc    <= 1'b0;
      ex_ALUop     <= '0;
      ex_MemRead   <= 1'b0;
      ex_MemWrite  <= 1'b0;
      ex_RegWrite  <= 1'b0;
      ex_MemToReg  <= 1'b0;
      if (!bus.flush && bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
    end else if (!bus.ext_hold) begin
      ex_valid     <= bus.id_valid;
      ex_D1        <= bus.id_D1;
      ex_D2        <= bus.id_D2;
      ex_Imm12     <= bus.id_Imm12;
      ex_Imm9      <= bus.id_Imm9;
      ex_Rn        <= bus.id_Rn;
      ex_Rm        <= bus.id_Rm;
      ex_Rd        <= bus.id_Rd;
      ex_LDUR_STUR <= bus.id_LDUR_STUR;
      ex_ALUsrc    <= bus.id_ALUsrc;
      ex_ALUop     <= bus.id_ALUop;
      ex_MemRead   <= bus.id_MemRead;
      ex_MemWrite  <= bus.id_MemWrite;
      ex_RegWrite  <= bus.id_RegWrite;
      ex_MemToReg  <= bus.id_MemToReg;
    end
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_D1        = ex_D1;
  assign bus.ex_D2        = ex_D2;
  assign bus.ex_Imm12     = ex_Imm12;
  assign bus.ex_Imm9      = ex_Imm9;
  assign bus.ex_Rn        = ex_Rn;
  assign bus.ex_Rm        = ex_Rm;
  assign bus.ex_Rd        = ex_Rd;
  assign bus.ex_LDUR_STUR = ex_LDUR_STUR;
  assign bus.ex_ALUsrc    = ex_ALUsrc;
  assign bus.ex_ALUop     = ex_ALUop;
  assign bus.ex_MemRead   = ex_MemRead;
  assign bus.ex_MemWrite  = ex_MemWrite;
  assign bus.ex_RegWrite  = ex_RegWrite;
  assign bus.ex_MemToReg  = ex_MemToReg;
  assign bus.hazard_stall = hazard_stall;
  assign bus.bubble_count = bubble_count;
endmodule
